branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side branch prediction unit for the 5-stage RISC-V pipeline. It produces the prediction and resolution signals that the decode/flush logic consumes: predict-taken, predicted PC, mispredict and redirect PC.
- Direct-mapped BTB combined with a 2-bit saturating BHT. The tables are looked up with the IF PC and trained by the EX stage.
- Mispredict and redirect are resolved combinationally in EX so the same-cycle IF/ID and ID/EX flush path is preserved.

Parameters:
- PC_WIDTH, 32, width of every PC and target bus.
- INDEX_BITS, 6, table index width. ENTRIES = 2**INDEX_BITS. Index = PC[INDEX_BITS+1:2]. Tag = PC[PC_WIDTH-1:INDEX_BITS+2].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IF_PC  in  PC_WIDTH  fetch PC for lookup.
- Predict_Taken  out  1  IF prediction.
- Predict_PC  out  PC_WIDTH  predicted next fetch PC.
- EX_Valid  in  1  EX stage holds a real instruction (0 for bubble/flushed).
- EX_Branch  in  1  EX instruction is B-type.
- EX_Jump  in  1  EX instruction is JAL/JALR.
- EX_PC  in  PC_WIDTH  PC of EX instruction.
- EX_Target  in  PC_WIDTH  computed branch/jump target.
- EX_Taken  in  1  branch condition result.
- EX_Predict_Taken  in  1  prediction carried down the pipeline with the instruction.
- EX_Predict_PC  in  PC_WIDTH  predicted PC carried down the pipeline.
- Mispredict  out  1  flush request.
- Redirect_PC  out  PC_WIDTH  corrected fetch PC.
- Branch_Count  out  32  resolved control instructions (see Optional Feature).
- Mispredict_Count  out  32  mispredicts (see Optional Feature).

Behaviour:
- Per-entry state: valid, tag, target, is_jump, ctr[1:0]. Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset (async, rst_n=0): all valid=0, all ctr=01; tag, target and is_jump are don't-care.
  - Outputs during reset: Predict_Taken=0, Predict_PC=IF_PC+4, Mispredict=0, Redirect_PC=EX_PC+4, counters=0.
- Lookup is combinational with 0-cycle latency.
  - hit = valid && tag match. Predict_Taken = hit && ctr[1].
  - Predict_PC = Predict_Taken ? target : IF_PC+4. All PC addition wraps modulo 2^PC_WIDTH.
- Resolution is combinational, active only when EX_Valid=1.
  - actual_taken = EX_Jump | (EX_Branch & EX_Taken). Redirect_PC = actual_taken ? EX_Target : EX_PC+4.
  - For control instructions: Mispredict = (EX_Predict_Taken != actual_taken) | (actual_taken & (EX_Predict_PC != EX_Target)).
  - For non-control instructions with EX_Predict_Taken=1 (alias): Mispredict=1, Redirect_PC=EX_PC+4.
  - When EX_Valid=0: Mispredict=0.
- Update happens at the rising edge when EX_Valid=1, indexed by EX_PC:
  - Branch hit: ctr saturating +1 if taken, -1 if not taken (11 stays 11, 00 stays 00). If taken, target <= EX_Target.
  - Branch miss and taken: allocate (overwrite) with valid=1, tag, target, is_jump=0, ctr=10.
  - Branch miss and not taken: no write.
  - Jump (hit or miss): valid=1, tag, target <= EX_Target, is_jump=1, ctr=11.
  - Non-control instruction with tag hit: valid <= 0, invalidating the aliased entry.
  - Counters of entries with is_jump=1 stay at 11 until reallocated by a branch.
- Same-cycle lookup and update to the same index: lookup returns the pre-update value (read-before-write). The new value is visible the next cycle.
- Tables are not cleared by pipeline flushes; only rst_n clears them. Reset asserted mid-update: the write is discarded.

Optional Feature:
- Macro: BP_PERF_CNT_EN.
- Defined: Branch_Count increments on every edge with EX_Valid & (EX_Branch|EX_Jump). Mispredict_Count increments on every edge with Mispredict=1. Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: counter registers are not built; both ports are tied to 0, keeping the port list unchanged.

Test Plan:
- Reset: rst_n=0, IF_PC=0x100 -> Predict_Taken=0, Predict_PC=0x104. After release, lookup at any PC misses.
- Cold taken branch: EX_PC=0x100, EX_Branch=1, EX_Taken=1, EX_Target=0x80, EX_Predict_Taken=0 -> Mispredict=1, Redirect_PC=0x80. Next cycle IF_PC=0x100 -> Predict_Taken=1, Predict_PC=0x80.
- Counter hysteresis: from ctr=10, one not-taken resolve of 0x100 -> ctr=01, Predict_Taken=0. Resolve taken twice -> ctr=11. One not-taken -> still predicts taken.
- JALR target change: entry 0x200->0x400; resolve EX_Jump=1, EX_Target=0x500, EX_Predict_Taken=1, EX_Predict_PC=0x400 -> Mispredict=1, Redirect_PC=0x500. Next lookup of 0x200 gives Predict_PC=0x500.
- Alias: 0x100 and 0x200 share an index (INDEX_BITS=6); 0x100 allocated. Resolve EX_PC=0x200 as non-branch -> Mispredict=0 if EX_Predict_Taken=0 and the 0x100 entry is kept (tag mismatch). Repeat with the entry's tag matching and EX_Predict_Taken=1 -> Mispredict=1, Redirect_PC=EX_PC+4, entry invalidated.
- Bypass/perf: same-cycle update and lookup of 0x100 returns the old prediction. With BP_PERF_CNT_EN, 5 branches including 2 mispredicts -> Branch_Count=5, Mispredict_Count=2.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB + 2-bit BHT, trained from EX; optional perf counters under BP_PERF_CNT_EN.
// Latency: lookup and mispredict/redirect resolution are combinational (0 cycles); table updates land at the next rising edge.
// Backpressure: none; an update is accepted on every cycle with EX_Valid=1 and the unit never stalls.
module branch_predictor #(
   parameter int PC_WIDTH   = 32,
   parameter int INDEX_BITS = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [PC_WIDTH-1:0] IF_PC,
   output logic                Predict_Taken,
   output logic [PC_WIDTH-1:0] Predict_PC,
   input  logic                EX_Valid,
   input  logic                EX_Branch,
   input  logic                EX_Jump,
   input  logic [PC_WIDTH-1:0] EX_PC,
   input  logic [PC_WIDTH-1:0] EX_Target,
   input  logic                EX_Taken,
   input  logic                EX_Predict_Taken,
   input  logic [PC_WIDTH-1:0] EX_Predict_PC,
   output logic                Mispredict,
   output logic [PC_WIDTH-1:0] Redirect_PC,
   output logic [31:0]         Branch_Count,
   output logic [31:0]         Mispredict_Count
);

   localparam int ENTRIES = 2 ** INDEX_BITS;
   localparam int TAG_W   = PC_WIDTH - INDEX_BITS - 2;

   // Only valid and the counters need a reset value; tag/target/is_jump are qualified by valid.
   logic [ENTRIES-1:0]  valid_q;
   logic [1:0]          ctr_q    [ENTRIES];
   logic [TAG_W-1:0]    tag_q    [ENTRIES];
   logic [PC_WIDTH-1:0] target_q [ENTRIES];
   logic [ENTRIES-1:0]  is_jump_q;

   logic [INDEX_BITS-1:0] if_idx, ex_idx;
   logic [TAG_W-1:0]      if_tag, ex_tag;
   logic                  if_hit, ex_hit, actual_taken, is_ctrl;

   // Word-aligned PCs: the two low bits never select an entry.
   logic unused_pc_lsbs;
   assign unused_pc_lsbs = ^{IF_PC[1:0], EX_PC[1:0]};

   assign if_idx = IF_PC[INDEX_BITS+1:2];
   assign if_tag = IF_PC[PC_WIDTH-1:INDEX_BITS+2];
   assign ex_idx = EX_PC[INDEX_BITS+1:2];
   assign ex_tag = EX_PC[PC_WIDTH-1:INDEX_BITS+2];

   assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
   assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

   // Fetch lookup; reads the registered table, so a same-cycle update is not visible yet.
   always_comb begin
      Predict_Taken = if_hit && ctr_q[if_idx][1];
      Predict_PC    = Predict_Taken ? target_q[if_idx] : IF_PC + PC_WIDTH'(4);
   end

   assign is_ctrl      = EX_Branch | EX_Jump;
   assign actual_taken = EX_Jump | (EX_Branch & EX_Taken);

   // EX resolution; a predicted-taken non-control instruction is an alias and falls through to PC+4.
   always_comb begin
      Mispredict  = 1'b0;
      Redirect_PC = EX_PC + PC_WIDTH'(4);
      if (rst_n && EX_Valid) begin
         if (actual_taken)
            Redirect_PC = EX_Target;
         if (is_ctrl)
            Mispredict = (EX_Predict_Taken != actual_taken) |
                         (actual_taken & (EX_Predict_PC != EX_Target));
         else
            Mispredict = EX_Predict_Taken;
      end
   end

   logic       upd_valid_en, upd_valid_val, upd_ctr_en, upd_meta_en, upd_is_jump, upd_tgt_en;
   logic [1:0] upd_ctr;

   // Training decision; jump entries are not trained by branches, only reallocated on a taken branch.
   always_comb begin
      upd_valid_en  = 1'b0;
      upd_valid_val = 1'b0;
      upd_ctr_en    = 1'b0;
      upd_ctr       = ctr_q[ex_idx];
      upd_meta_en   = 1'b0;
      upd_is_jump   = 1'b0;
      upd_tgt_en    = 1'b0;
      if (EX_Valid) begin
         if (EX_Jump) begin
            upd_valid_en  = 1'b1;
            upd_valid_val = 1'b1;
            upd_ctr_en    = 1'b1;
            upd_ctr       = 2'b11;
            upd_meta_en   = 1'b1;
            upd_is_jump   = 1'b1;
            upd_tgt_en    = 1'b1;
         end else if (EX_Branch) begin
            if (ex_hit && !is_jump_q[ex_idx]) begin
               upd_ctr_en = 1'b1;
               if (EX_Taken)
                  upd_ctr = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
               else
                  upd_ctr = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
               upd_tgt_en = EX_Taken;
            end else if (EX_Taken) begin
               upd_valid_en  = 1'b1;
               upd_valid_val = 1'b1;
               upd_ctr_en    = 1'b1;
               upd_ctr       = 2'b10;
               upd_meta_en   = 1'b1;
               upd_tgt_en    = 1'b1;
            end
         end else if (ex_hit) begin
            upd_valid_en  = 1'b1;
            upd_valid_val = 1'b0;
         end
      end
   end

   // Valid bits and counters; reset clears them and overrides any in-flight write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++)
            ctr_q[i] <= 2'b01;
      end else begin
         if (upd_valid_en)
            valid_q[ex_idx] <= upd_valid_val;
         if (upd_ctr_en)
            ctr_q[ex_idx] <= upd_ctr;
      end
   end

   // Tag/target/kind payload; a write during reset is harmless because valid stays cleared.
   always_ff @(posedge clk) begin
      if (upd_meta_en) begin
         tag_q[ex_idx]     <= ex_tag;
         is_jump_q[ex_idx] <= upd_is_jump;
      end
      if (upd_tgt_en)
         target_q[ex_idx] <= EX_Target;
   end

`ifdef BP_PERF_CNT_EN
   logic [31:0] br_cnt_q, mp_cnt_q;

   // Saturating counts of resolved control instructions and of flush requests.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_cnt_q <= '0;
         mp_cnt_q <= '0;
      end else begin
         if (EX_Valid && is_ctrl && (br_cnt_q != 32'hFFFF_FFFF))
            br_cnt_q <= br_cnt_q + 32'd1;
         if (Mispredict && (mp_cnt_q != 32'hFFFF_FFFF))
            mp_cnt_q <= mp_cnt_q + 32'd1;
      end
   end

   assign Branch_Count     = br_cnt_q;
   assign Mispredict_Count = mp_cnt_q;
`else
   assign Branch_Count     = '0;
   assign Mispredict_Count = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reset, allocation, hysteresis, jumps, aliasing, bypass, perf counters.
module tb_branch_predictor;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] IF_PC;
   logic        Predict_Taken;
   logic [31:0] Predict_PC;
   logic        EX_Valid, EX_Branch, EX_Jump, EX_Taken, EX_Predict_Taken;
   logic [31:0] EX_PC, EX_Target, EX_Predict_PC;
   logic        Mispredict;
   logic [31:0] Redirect_PC, Branch_Count, Mispredict_Count;

   int n_vec = 0;
   int n_err = 0;

   branch_predictor #(.PC_WIDTH(32), .INDEX_BITS(6)) dut (
      .clk(clk), .rst_n(rst_n), .IF_PC(IF_PC),
      .Predict_Taken(Predict_Taken), .Predict_PC(Predict_PC),
      .EX_Valid(EX_Valid), .EX_Branch(EX_Branch), .EX_Jump(EX_Jump),
      .EX_PC(EX_PC), .EX_Target(EX_Target), .EX_Taken(EX_Taken),
      .EX_Predict_Taken(EX_Predict_Taken), .EX_Predict_PC(EX_Predict_PC),
      .Mispredict(Mispredict), .Redirect_PC(Redirect_PC),
      .Branch_Count(Branch_Count), .Mispredict_Count(Mispredict_Count)
   );

   always #5 clk = ~clk;

   // Drive one EX resolution at the falling edge; it commits at the following rising edge.
   task automatic ex(input logic v, input logic br, input logic jp, input logic [31:0] pc,
                     input logic [31:0] tgt, input logic tk, input logic ppt, input logic [31:0] ppc);
      @(negedge clk);
      EX_Valid = v; EX_Branch = br; EX_Jump = jp; EX_PC = pc; EX_Target = tgt;
      EX_Taken = tk; EX_Predict_Taken = ppt; EX_Predict_PC = ppc;
      #1;
   endtask

   // Idle EX and present a fetch PC at the falling edge.
   task automatic look(input logic [31:0] pc);
      @(negedge clk);
      EX_Valid = 1'b0; EX_Branch = 1'b0; EX_Jump = 1'b0; EX_Taken = 1'b0; EX_Predict_Taken = 1'b0;
      IF_PC = pc;
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; IF_PC = 32'h100;
      EX_Valid = 1'b1; EX_Branch = 1'b1; EX_Jump = 1'b0; EX_Taken = 1'b1;
      EX_PC = 32'h40; EX_Target = 32'h80; EX_Predict_Taken = 1'b0; EX_Predict_PC = 32'h44;
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (Predict_Taken !== 1'b0) begin n_err++; $display("FAIL rst_pt got %0b want 0", Predict_Taken); end
      n_vec++; if (Predict_PC !== 32'h104) begin n_err++; $display("FAIL rst_ppc got %h want 00000104", Predict_PC); end
      n_vec++; if (Mispredict !== 1'b0) begin n_err++; $display("FAIL rst_mp got %0b want 0", Mispredict); end
      n_vec++; if (Redirect_PC !== 32'h44) begin n_err++; $display("FAIL rst_rpc got %h want 00000044", Redirect_PC); end
      n_vec++; if (Branch_Count !== 32'd0 || Mispredict_Count !== 32'd0) begin n_err++; $display("FAIL rst_cnt got %0d/%0d want 0/0", Branch_Count, Mispredict_Count); end
      @(negedge clk);
      EX_Valid = 1'b0;
      rst_n = 1'b1;
      look(32'h100);
      n_vec++; if (Predict_Taken !== 1'b0) begin n_err++; $display("FAIL rst_miss100 got %0b want 0", Predict_Taken); end
      look(32'h40);
      n_vec++; if (Predict_Taken !== 1'b0 || Predict_PC !== 32'h44) begin n_err++; $display("FAIL rst_discard got %0b/%h want 0/00000044", Predict_Taken, Predict_PC); end
      look(32'hFFFF_FFFC);
      n_vec++; if (Predict_PC !== 32'h0) begin n_err++; $display("FAIL wrap_ppc got %h want 00000000", Predict_PC); end
   endtask

   task automatic test_cold_taken;
      ex(1, 1, 0, 32'h100, 32'h80, 1, 0, 32'h104);
      n_vec++; if (Mispredict !== 1'b1) begin n_err++; $display("FAIL cold_mp got %0b want 1", Mispredict); end
      n_vec++; if (Redirect_PC !== 32'h80) begin n_err++; $display("FAIL cold_rpc got %h want 00000080", Redirect_PC); end
      look(32'h100);
      n_vec++; if (Predict_Taken !== 1'b1 || Predict_PC !== 32'h80) begin n_err++; $display("FAIL cold_look got %0b/%h want 1/00000080", Predict_Taken, Predict_PC); end
   endtask

   task automatic test_hysteresis;
      // ctr 10 -> 01
      ex(1, 1, 0, 32'h100, 32'h80, 0, 1, 32'h80);
      n_vec++; if (Mispredict !== 1'b1 || Redirect_PC !== 32'h104) begin n_err++; $display("FAIL hyst_nt got %0b/%h want 1/00000104", Mispredict, Redirect_PC); end
      look(32'h100);
      n_vec++; if (Predict_Taken !== 1'b0 || Predict_PC !== 32'h104) begin n_err++; $display("FAIL hyst_01 got %0b/%h want 0/00000104", Predict_Taken, Predict_PC); end
      // 01 -> 10 -> 11
      ex(1, 1, 0, 32'h100, 32'h80, 1, 0, 32'h104);
      look(32'h100);
      n_vec++; if (Predict_Taken !== 1'b1) begin n_err++; $display("FAIL hyst_10 got %0b want 1", Predict_Taken); end
      ex(1, 1, 0, 32'h100, 32'h80, 1, 1, 32'h80);
      n_vec++; if (Mispredict !== 1'b0) begin n_err++; $display("FAIL hyst_correct got %0b want 0", Mispredict); end
      // 11 -> 10 still predicts taken
      ex(1, 1, 0, 32'h100, 32'h80, 0, 1, 32'h80);
      look(32'h100);
      n_vec++; if (Predict_Taken !== 1'b1 || Predict_PC !== 32'h80) begin n_err++; $display("FAIL hyst_strong got %0b/%h want 1/00000080", Predict_Taken, Predict_PC); end
      // 10 -> 01 -> 00 -> 00, then one taken gives 01: not taken
      ex(1, 1, 0, 32'h100, 32'h80, 0, 1, 32'h80);
      ex(1, 1, 0, 32'h100, 32'h80, 0, 0, 32'h104);
      ex(1, 1, 0, 32'h100, 32'h80, 0, 0, 32'h104);
      ex(1, 1, 0, 32'h100, 32'h80, 1, 0, 32'h104);
      look(32'h100);
      n_vec++; if (Predict_Taken !== 1'b0) begin n_err++; $display("FAIL hyst_sat00 got %0b want 0", Predict_Taken); end
   endtask

   task automatic test_jalr;
      ex(1, 0, 1, 32'h200, 32'h400, 0, 0, 32'h204);
      n_vec++; if (Mispredict !== 1'b1 || Redirect_PC !== 32'h400) begin n_err++; $display("FAIL jal_cold got %0b/%h want 1/00000400", Mispredict, Redirect_PC); end
      look(32'h200);
      n_vec++; if (Predict_Taken !== 1'b1 || Predict_PC !== 32'h400) begin n_err++; $display("FAIL jal_look got %0b/%h want 1/00000400", Predict_Taken, Predict_PC); end
      ex(1, 0, 1, 32'h200, 32'h500, 0, 1, 32'h400);
      n_vec++; if (Mispredict !== 1'b1 || Redirect_PC !== 32'h500) begin n_err++; $display("FAIL jalr_tgt got %0b/%h want 1/00000500", Mispredict, Redirect_PC); end
      look(32'h200);
      n_vec++; if (Predict_PC !== 32'h500) begin n_err++; $display("FAIL jalr_look got %h want 00000500", Predict_PC); end
      ex(1, 0, 1, 32'h200, 32'h500, 0, 1, 32'h500);
      n_vec++; if (Mispredict !== 1'b0) begin n_err++; $display("FAIL jalr_ok got %0b want 0", Mispredict); end
      look(32'h100);
      n_vec++; if (Predict_Taken !== 1'b0) begin n_err++; $display("FAIL jal_evict got %0b want 0", Predict_Taken); end
   endtask

   task automatic test_alias;
      ex(1, 1, 0, 32'h100, 32'h80, 1, 0, 32'h104);
      ex(1, 0, 0, 32'h200, 32'h0, 0, 0, 32'h204);
      n_vec++; if (Mispredict !== 1'b0 || Redirect_PC !== 32'h204) begin n_err++; $display("FAIL alias_nomatch got %0b/%h want 0/00000204", Mispredict, Redirect_PC); end
      look(32'h100);
      n_vec++; if (Predict_Taken !== 1'b1 || Predict_PC !== 32'h80) begin n_err++; $display("FAIL alias_kept got %0b/%h want 1/00000080", Predict_Taken, Predict_PC); end
      ex(1, 0, 0, 32'h100, 32'h0, 0, 1, 32'h80);
      n_vec++; if (Mispredict !== 1'b1 || Redirect_PC !== 32'h104) begin n_err++; $display("FAIL alias_hit got %0b/%h want 1/00000104", Mispredict, Redirect_PC); end
      look(32'h100);
      n_vec++; if (Predict_Taken !== 1'b0 || Predict_PC !== 32'h104) begin n_err++; $display("FAIL alias_inval got %0b/%h want 0/00000104", Predict_Taken, Predict_PC); end
      ex(0, 1, 0, 32'h300, 32'h10, 1, 0, 32'h304);
      n_vec++; if (Mispredict !== 1'b0 || Redirect_PC !== 32'h304) begin n_err++; $display("FAIL bubble got %0b/%h want 0/00000304", Mispredict, Redirect_PC); end
   endtask

   task automatic test_bypass;
      ex(1, 1, 0, 32'h100, 32'h80, 1, 0, 32'h104);   // allocate ctr=10
      @(negedge clk);
      IF_PC = 32'h100;
      EX_Valid = 1'b1; EX_Branch = 1'b1; EX_Jump = 1'b0; EX_PC = 32'h100; EX_Target = 32'h80;
      EX_Taken = 1'b0; EX_Predict_Taken = 1'b1; EX_Predict_PC = 32'h80;
      #1;
      n_vec++; if (Predict_Taken !== 1'b1 || Predict_PC !== 32'h80) begin n_err++; $display("FAIL bypass_old got %0b/%h want 1/00000080", Predict_Taken, Predict_PC); end
      look(32'h100);
      n_vec++; if (Predict_Taken !== 1'b0) begin n_err++; $display("FAIL bypass_new got %0b want 0", Predict_Taken); end
   endtask

   task automatic test_perf;
      @(negedge clk);
      rst_n = 1'b0; EX_Valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      ex(1, 1, 0, 32'h10, 32'h80, 1, 0, 32'h14);   // mispredict
      ex(1, 1, 0, 32'h10, 32'h80, 1, 1, 32'h80);   // correct
      ex(1, 0, 0, 32'h20, 32'h0, 0, 0, 32'h24);    // not control
      ex(1, 1, 0, 32'h14, 32'h90, 0, 0, 32'h18);   // correct not-taken
      ex(1, 0, 1, 32'h18, 32'hA0, 0, 0, 32'h1C);   // mispredict
      ex(0, 1, 0, 32'h30, 32'h0, 1, 0, 32'h34);    // bubble
      ex(1, 1, 0, 32'h10, 32'h80, 1, 1, 32'h80);   // correct
      look(32'h0);
`ifdef BP_PERF_CNT_EN
      n_vec++; if (Branch_Count !== 32'd5) begin n_err++; $display("FAIL perf_br got %0d want 5", Branch_Count); end
      n_vec++; if (Mispredict_Count !== 32'd2) begin n_err++; $display("FAIL perf_mp got %0d want 2", Mispredict_Count); end
`else
      n_vec++; if (Branch_Count !== 32'd0) begin n_err++; $display("FAIL perf_br got %0d want 0", Branch_Count); end
      n_vec++; if (Mispredict_Count !== 32'd0) begin n_err++; $display("FAIL perf_mp got %0d want 0", Mispredict_Count); end
`endif
   endtask

   initial begin
      test_reset();
      test_cold_taken();
      test_hysteresis();
      test_jalr();
      test_alias();
      test_bypass();
      test_perf();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
